instruction_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_hold_buffer.sv | 32 +++
 rtl/instruction_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default constants for the IF stage
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'h00000000;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFFFFFF;
  localparam logic [31:0] DEF_NOP_WORD  = 32'h00000000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - parks an {instruction, pcPlus4} pair while IF/ID is stalled
module fetch_hold_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [63:0] i_data,
  output logic [63:0] o_data,
  output logic        o_valid
);

  logic [63:0] r_data;
  logic        r_valid;

  // Clear wins so a redirect can never resurrect a parked word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 64'd0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_data  <= 64'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: PC owner, single-outstanding imem fetch, stall/redirect/halt
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD,
  parameter logic [31:0] NOP_WORD  = DEF_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4,
  output logic        instrValid,
  output logic        endProgram
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instruction;
  logic [31:0]  r_pcplus4;
  logic         r_imem_req;
  logic         r_instr_valid;
  logic         r_end_program;
  logic         r_drop;

  logic [31:0]  w_pc_next4;
  logic [31:0]  w_target;
  logic         w_hb_load;
  logic         w_hb_clear;
  logic [63:0]  w_hb_data;
  logic         w_hb_valid;

  assign w_pc_next4 = r_pc + 32'd4;
  assign w_target   = align_word(redirectTarget);
  assign w_hb_load  = (r_state == WAIT) && imemValid && !r_drop && !redirect && stall;
  assign w_hb_clear = (r_state == HOLD) && (redirect || !stall);

  fetch_hold_buffer u_hold (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_hb_load),
    .i_clear (w_hb_clear),
    .i_data  ({imemData, w_pc_next4}),
    .o_data  (w_hb_data),
    .o_valid (w_hb_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_instruction <= NOP_WORD;
      r_pcplus4     <= 32'd0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_end_program <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      r_instruction <= NOP_WORD;
      case (r_state)
        FETCH: begin
          if (r_imem_req && imemReady) begin
            // An accepted request must still drain even if redirected away.
            r_state    <= WAIT;
            r_imem_req <= 1'b0;
            r_drop     <= redirect;
          end else begin
            r_imem_req <= 1'b1;
          end
          if (redirect) r_pc <= w_target;
        end
        WAIT: begin
          if (redirect) begin
            r_pc <= w_target;
            if (imemValid) begin
              r_drop     <= 1'b0;
              r_state    <= FETCH;
              r_imem_req <= 1'b1;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (imemValid) begin
            if (r_drop) begin
              r_drop     <= 1'b0;
              r_state    <= FETCH;
              r_imem_req <= 1'b1;
            end else if (stall) begin
              r_state <= HOLD;
            end else begin
              r_instruction <= imemData;
              r_pcplus4     <= w_pc_next4;
              r_instr_valid <= 1'b1;
              r_pc          <= w_pc_next4;
              if (imemData == HALT_WORD) begin
                r_end_program <= 1'b1;
                r_state       <= HALT;
              end else begin
                r_state    <= FETCH;
                r_imem_req <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            r_pc       <= w_target;
            r_state    <= FETCH;
            r_imem_req <= 1'b1;
          end else if (!stall) begin
            r_pc      <= w_pc_next4;
            r_pcplus4 <= w_hb_data[31:0];
            if (w_hb_data[63:32] == HALT_WORD) begin
              r_end_program <= 1'b1;
              r_state       <= HALT;
            end else begin
              r_state    <= FETCH;
              r_imem_req <= 1'b1;
            end
          end
        end
        HALT: begin
          r_imem_req <= 1'b0;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  // While parked, the hold buffer drives IF/ID directly.
  assign imemReq     = r_imem_req;
  assign imemAddr    = r_pc;
  assign instruction = w_hb_valid ? w_hb_data[63:32] : r_instruction;
  assign pcPlus4     = w_hb_valid ? w_hb_data[31:0] : r_pcplus4;
  assign instrValid  = w_hb_valid | r_instr_valid;
  assign endProgram  = r_end_program;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam logic [31:0] T_RESET_PC = 32'h00000000;
  localparam logic [31:0] T_HALT     = 32'hFFFFFFFF;
  localparam logic [31:0] T_NOP      = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imemReady, imemValid;
  logic [31:0] redirectTarget, imemData;
  logic        imemReq, instrValid, endProgram;
  logic [31:0] imemAddr, instruction, pcPlus4;

  logic        w_reset, w_zero, w_ready, w_valid, w_req, w_iv, w_end;
  logic [31:0] w_zero32, w_data, w_addr, w_instr, w_pc4;

  always #5 clk = ~clk;

  instruction_fetch_unit u_dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirectTarget(redirectTarget), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemReady(imemReady), .imemValid(imemValid), .imemData(imemData),
    .instruction(instruction), .pcPlus4(pcPlus4), .instrValid(instrValid),
    .endProgram(endProgram)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
    .clk(clk), .reset(w_reset), .stall(w_zero), .redirect(w_zero),
    .redirectTarget(w_zero32), .imemReq(w_req), .imemAddr(w_addr),
    .imemReady(w_ready), .imemValid(w_valid), .imemData(w_data),
    .instruction(w_instr), .pcPlus4(w_pc4), .instrValid(w_iv),
    .endProgram(w_end)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: architectural PC, pending consumption, halt flag.
  logic [31:0] m_pc;
  logic [31:0] m_held_word;
  bit          m_halted, m_held;
  // Memory model: one outstanding request with random latency.
  bit          pend, pend_stale;
  int          lat;
  logic [31:0] pend_addr;
  // Knobs.
  int stall_pct, redir_pct, ready_pct, lat_max;
  bit all_halt, wrap_done;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (all_halt) return T_HALT;
    if (a == 32'd0) return 32'h20010005;
    return ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A) & 32'hFFFFFFFE;
  endfunction

  initial begin : driver
    logic        v_valid, v_stale, v_redir, v_stall, v_ready;
    logic [31:0] v_data, v_addr, v_target;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall = 1'b0; redirect = 1'b0; imemReady = 1'b0; imemValid = 1'b0;
        pend = 1'b0; pend_stale = 1'b0;
        m_pc = T_RESET_PC; m_halted = 1'b0; m_held = 1'b0;
        exp_q.delete();
        continue;
      end
      v_valid  = 1'b0; v_stale = 1'b0; v_data = 32'd0; v_addr = 32'd0;
      v_redir  = ($urandom_range(0, 99) < redir_pct);
      v_stall  = ($urandom_range(0, 99) < stall_pct);
      v_ready  = ($urandom_range(0, 99) < ready_pct);
      v_target = $urandom_range(0, 255);
      if (pend) begin
        if (v_redir) pend_stale = 1'b1;
        if (lat == 0) begin
          v_valid = 1'b1; v_addr = pend_addr; v_data = memword(pend_addr);
          v_stale = pend_stale; pend = 1'b0;
        end else begin
          lat--;
        end
      end
      if (m_halted) check1("req_after_halt", imemReq, 1'b0);
      if (imemReq && v_ready) begin
        check32("fetch_addr", imemAddr, m_pc);
        check1("one_outstanding", pend, 1'b0);
        pend = 1'b1; pend_stale = v_redir; pend_addr = imemAddr;
        lat = $urandom_range(0, lat_max);
      end
      if (!m_halted) begin
        if (v_redir) begin
          m_pc = v_target & ~32'd3;
          m_held = 1'b0;
        end else if (v_valid && !v_stale) begin
          exp_q.push_back('{v_data, v_addr + 32'd4});
          if (v_stall) begin
            m_held = 1'b1; m_held_word = v_data;
          end else begin
            m_pc = m_pc + 32'd4;
            if (v_data == T_HALT) m_halted = 1'b1;
          end
        end else if (m_held && !v_stall) begin
          m_held = 1'b0;
          m_pc = m_pc + 32'd4;
          if (m_held_word == T_HALT) m_halted = 1'b1;
        end
      end
      stall = v_stall; redirect = v_redir; redirectTarget = v_target;
      imemReady = v_ready; imemValid = v_valid;
      imemData = v_valid ? v_data : $urandom;
    end
  end

  initial begin : monitor
    logic        prev_v;
    logic [31:0] prev_instr;
    exp_t        e;
    prev_v = 1'b0; prev_instr = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        prev_v = 1'b0;
        continue;
      end
      check1("end_program", endProgram, m_halted);
      if (instrValid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr actual=%h required=none", instruction);
        end else begin
          e = exp_q.pop_front();
          check32("instruction", instruction, e.instr);
          check32("pc_plus4", pcPlus4, e.pc4);
        end
      end else if (instrValid) begin
        check32("hold_stable", instruction, prev_instr);
      end else begin
        check32("nop_idle", instruction, T_NOP);
      end
      prev_v = instrValid; prev_instr = instruction;
    end
  end

  initial begin : wrap_test
    bit seen;
    w_reset = 1'b0; w_zero = 1'b0; w_zero32 = 32'd0;
    w_ready = 1'b0; w_valid = 1'b0; w_data = 32'd0; wrap_done = 1'b0;
    repeat (2) @(negedge clk);
    w_reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = w_req;
    end
    check1("wrap_first_req", seen, 1'b1);
    check32("wrap_first_addr", w_addr, 32'hFFFFFFFC);
    w_ready = 1'b1;
    @(negedge clk);
    w_ready = 1'b0; w_valid = 1'b1; w_data = 32'hA5A50001;
    @(negedge clk);
    w_valid = 1'b0;
    check1("wrap_valid", w_iv, 1'b1);
    check32("wrap_instr", w_instr, 32'hA5A50001);
    check32("wrap_pc4", w_pc4, 32'd0);
    check1("wrap_second_req", w_req, 1'b1);
    check32("wrap_second_addr", w_addr, 32'd0);
    wrap_done = 1'b1;
  end

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin : main
    bit found;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirectTarget = 32'd0;
    imemReady = 1'b0; imemValid = 1'b0; imemData = 32'd0;
    stall_pct = 0; redir_pct = 0; ready_pct = 100; lat_max = 0; all_halt = 1'b0;
    repeat (3) @(negedge clk);
    check1("rst_req", imemReq, 1'b0);
    check32("rst_addr", imemAddr, T_RESET_PC);
    check1("rst_valid", instrValid, 1'b0);
    check32("rst_instr", instruction, T_NOP);
    check32("rst_pc4", pcPlus4, 32'd0);
    check1("rst_end", endProgram, 1'b0);
    release_reset();
    repeat (40) @(negedge clk);

    stall_pct = 40; redir_pct = 8; ready_pct = 60; lat_max = 3;
    repeat (1500) @(negedge clk);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #2;
      found = pend && !imemReq && !instrValid;
    end
    check1("wait_found", found, 1'b1);
    reset = 1'b0;
    #1;
    check1("async_rst_req", imemReq, 1'b0);
    check32("async_rst_addr", imemAddr, T_RESET_PC);
    check1("async_rst_valid", instrValid, 1'b0);
    check32("async_rst_instr", instruction, T_NOP);
    check32("async_rst_pc4", pcPlus4, 32'd0);

    stall_pct = 100; redir_pct = 0; ready_pct = 100; lat_max = 1; all_halt = 1'b1;
    repeat (3) @(negedge clk);
    release_reset();
    repeat (12) @(negedge clk);
    check1("halt_parked_no_end", endProgram, 1'b0);
    check1("halt_parked_valid", instrValid, 1'b1);
    stall_pct = 0;
    for (int i = 0; i < 50 && !m_halted; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check1("halt_from_hold_end", endProgram, 1'b1);
    redir_pct = 50;
    repeat (30) @(negedge clk);
    check1("halt_sticky", endProgram, 1'b1);

    assert_reset();
    redir_pct = 0; stall_pct = 0;
    repeat (3) @(negedge clk);
    release_reset();
    repeat (20) @(negedge clk);
    check1("halt_direct_end", endProgram, 1'b1);
    redir_pct = 50;
    repeat (20) @(negedge clk);
    check1("halt_direct_sticky", endProgram, 1'b1);

    for (int i = 0; i < 50 && !wrap_done; i++) @(negedge clk);
    check1("wrap_done", wrap_done, 1'b1);
    check32("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
